ad_decimator: RTL and testbench

Sample-rate reduction stage sitting directly upstream of the oscilloscope capture/trigger buffer. It takes the raw 12-bit ADC stream (one sample per `ad_clk`), reduces each window of 2^N samples to one output sample using a selectable reduction mode, and emits that sample with a single-cycle `deci_valid` strobe. `deci_data`/`deci_valid` drive the capture buffer's `ad_data`/`deci_valid` inputs directly, setting the timebase.

---
 rtl/scope_pkg.sv | 25 ++
 rtl/ad_decimator_if.sv | 27 ++
 rtl/deci_reduce.sv | 58 +++++
 rtl/ad_decimator.sv | 89 ++++++++
 tb/tb_ad_decimator.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/scope_pkg.sv
`default_nettype none
// ============================================================================
// Package  : scope_pkg
// Brief    : Shared widths, decimation mode encoding and exponent clamp for
//            the scope front end.
// Revision : 1.0 - initial release
// ============================================================================
package scope_pkg;

    localparam int DATA_W  = 12;
    localparam int MAX_EXP = 10;

    typedef enum logic [1:0] {
        DECI_POINT = 2'd0,
        DECI_AVG   = 2'd1,
        DECI_MAX   = 2'd2,
        DECI_MIN   = 2'd3
    } deci_mode_t;

    function automatic logic [3:0] clamp_exp(input logic [3:0] exp_in, input logic [3:0] exp_max);
        return (exp_in > exp_max) ? exp_max : exp_in;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad_decimator_if.sv
`default_nettype none
// ============================================================================
// Interface: ad_decimator_if
// Brief    : Raw ADC stream, decimation control and reduced-sample output.
// Revision : 1.0 - initial release
// ============================================================================
interface ad_decimator_if #(
    parameter int DATA_W = scope_pkg::DATA_W
);
    logic [DATA_W-1:0] ad_data;
    logic [3:0]        deci_exp;
    logic [1:0]        deci_mode;
    logic              deci_clr;
    logic [DATA_W-1:0] deci_data;
    logic              deci_valid;

    modport master (
        output ad_data, deci_exp, deci_mode, deci_clr,
        input  deci_data, deci_valid
    );

    modport slave (
        input  ad_data, deci_exp, deci_mode, deci_clr,
        output deci_data, deci_valid
    );
endinterface
`default_nettype wire

// File: rtl/deci_reduce.sv
`default_nettype none
// ============================================================================
// Module   : deci_reduce
// Brief    : Mode-selected accumulate / compare datapath; result includes the
//            current sample.
// Revision : 1.0 - initial release
// ============================================================================
module deci_reduce #(
    parameter int DATA_W  = scope_pkg::DATA_W,
    parameter int MAX_EXP = scope_pkg::MAX_EXP
) (
    input  wire logic                 ad_clk,
    input  wire logic                 rst_n,
    input  wire logic                 first,
    input  wire logic [DATA_W-1:0]    sample,
    input  scope_pkg::deci_mode_t     mode,
    input  wire logic [3:0]           exp,
    output logic      [DATA_W-1:0]    result
);
    import scope_pkg::*;

    localparam int ACC_W = DATA_W + MAX_EXP;

    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_acc_next;
    logic [ACC_W-1:0]  w_sample_ext;
    logic [DATA_W-1:0] w_held;

    always_comb begin
        w_sample_ext = ACC_W'(sample);
        w_held       = r_acc[DATA_W-1:0];
        w_acc_next   = r_acc;
        if (first) begin
            w_acc_next = w_sample_ext;
        end else begin
            case (mode)
                DECI_AVG: w_acc_next = r_acc + w_sample_ext;
                DECI_MAX: if (sample > w_held) w_acc_next = w_sample_ext;
                DECI_MIN: if (sample < w_held) w_acc_next = w_sample_ext;
                default:  w_acc_next = r_acc;
            endcase
        end
    end

    // Average is a plain truncating shift of the full-width window sum.
    assign result = (mode == DECI_AVG) ? DATA_W'(w_acc_next >> exp)
                                       : w_acc_next[DATA_W-1:0];

    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ad_decimator.sv
`default_nettype none
// ============================================================================
// Module   : ad_decimator
// Brief    : Reduces each 2^N-sample ADC window to one strobed output sample.
// Revision : 1.0 - initial release
// ============================================================================
module ad_decimator #(
    parameter int DATA_W  = scope_pkg::DATA_W,
    parameter int MAX_EXP = scope_pkg::MAX_EXP
) (
    input  wire logic     ad_clk,
    input  wire logic     rst_n,
    ad_decimator_if.slave bus
);
    import scope_pkg::*;

    localparam logic [MAX_EXP-1:0] C_ONE = MAX_EXP'(1);

    logic [MAX_EXP-1:0] r_cnt;
    logic [3:0]         r_exp;
    deci_mode_t         r_mode;
    logic               r_armed;
    logic [DATA_W-1:0]  r_deci_data;
    logic               r_deci_valid;

    logic [MAX_EXP-1:0] w_last_cnt;
    logic [3:0]         w_exp;
    deci_mode_t         w_mode;
    logic [DATA_W-1:0]  w_result;
    logic               w_first;
    logic               w_last;
    logic               w_idle;

    // At window start the live config governs, so a window never mixes settings.
    assign w_first    = (r_cnt == '0);
    assign w_exp      = w_first ? clamp_exp(bus.deci_exp, 4'(MAX_EXP)) : r_exp;
    assign w_mode     = w_first ? deci_mode_t'(bus.deci_mode) : r_mode;
    assign w_last_cnt = (C_ONE << w_exp) - C_ONE;
    assign w_last     = (r_cnt == w_last_cnt);
    // The first cycle after reset release is spent idle, like a clear.
    assign w_idle     = !r_armed || bus.deci_clr;

    deci_reduce #(
        .DATA_W  (DATA_W),
        .MAX_EXP (MAX_EXP)
    ) u_reduce (
        .ad_clk (ad_clk),
        .rst_n  (rst_n),
        .first  (w_first),
        .sample (bus.ad_data),
        .mode   (w_mode),
        .exp    (w_exp),
        .result (w_result)
    );

    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_exp        <= '0;
            r_mode       <= DECI_POINT;
            r_armed      <= 1'b0;
            r_deci_data  <= '0;
            r_deci_valid <= 1'b0;
        end else begin
            r_armed      <= 1'b1;
            r_deci_valid <= 1'b0;
            if (w_idle) begin
                r_cnt <= '0;
            end else begin
                if (w_first) begin
                    r_exp  <= w_exp;
                    r_mode <= w_mode;
                end
                if (w_last) begin
                    r_cnt        <= '0;
                    r_deci_data  <= w_result;
                    r_deci_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + C_ONE;
                end
            end
        end
    end

    assign bus.deci_data  = r_deci_data;
    assign bus.deci_valid = r_deci_valid;

endmodule
`default_nettype wire

// File: tb/tb_ad_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad_decimator
// Brief    : Directed stimulus with a window-queue reference model and
//            hand-computed strobe expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad_decimator;
    import scope_pkg::*;

    logic ad_clk = 1'b0;
    logic rst_n;

    ad_decimator_if #(.DATA_W(DATA_W)) bus();

    ad_decimator #(
        .DATA_W  (DATA_W),
        .MAX_EXP (MAX_EXP)
    ) dut (
        .ad_clk (ad_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 ad_clk = ~ad_clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned cyc     = 0;
    bit          chk_en  = 1'b0;

    // Reference model: the current window as a list of samples.
    int unsigned m_win[$];
    int unsigned m_exp   = 0;
    int unsigned m_mode  = 0;
    bit          m_armed = 1'b0;
    bit          m_valid = 1'b0;
    int unsigned m_data  = 0;

    int unsigned log_data[$];
    int unsigned log_cyc[$];

    task automatic check(input string name, input longint actual, input longint expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    function automatic int unsigned reduce_window();
        longint unsigned sum = 0;
        int unsigned hi = m_win[0];
        int unsigned lo = m_win[0];
        foreach (m_win[i]) begin
            sum += m_win[i];
            if (m_win[i] > hi) hi = m_win[i];
            if (m_win[i] < lo) lo = m_win[i];
        end
        case (m_mode)
            0:       return m_win[0];
            1:       return int'(sum / longint'(m_win.size()));
            2:       return hi;
            default: return lo;
        endcase
    endfunction

    always @(posedge ad_clk) begin
        cyc++;
        if (!rst_n) begin
            m_win.delete();
            m_armed = 1'b0;
            m_valid = 1'b0;
            m_data  = 0;
        end else if (!m_armed || bus.deci_clr) begin
            m_armed = 1'b1;
            m_win.delete();
            m_valid = 1'b0;
        end else begin
            if (m_win.size() == 0) begin
                m_exp  = (bus.deci_exp > MAX_EXP) ? MAX_EXP : bus.deci_exp;
                m_mode = bus.deci_mode;
            end
            m_win.push_back(bus.ad_data);
            if (m_win.size() == (1 << m_exp)) begin
                m_data  = reduce_window();
                m_valid = 1'b1;
                m_win.delete();
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    // Output cycle numbering: outputs changed at edge k belong to cycle k+1.
    always @(posedge ad_clk) begin
        #1;
        if (chk_en) begin
            check("valid_vs_model", bus.deci_valid, m_valid);
            check("data_vs_model", bus.deci_data, m_data);
            if (bus.deci_valid) begin
                log_data.push_back(bus.deci_data);
                log_cyc.push_back(cyc + 1);
            end
        end
    end

    task automatic drive(input int unsigned d);
        bus.ad_data = DATA_W'(d);
        @(negedge ad_clk);
    endtask

    task automatic pulse_clr(output int unsigned c);
        bus.deci_clr = 1'b1;
        bus.ad_data  = 12'hABC;
        c = cyc + 1;
        @(negedge ad_clk);
        bus.deci_clr = 1'b0;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_cyc.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;
        int unsigned rel;
        int unsigned win8[8] = '{5, 900, 12, 4095, 0, 7, 7, 3};
        int unsigned vals[6] = '{3, 4095, 0, 1234, 77, 2048};

        rst_n         = 1'b0;
        bus.ad_data   = '0;
        bus.deci_exp  = 4'd2;
        bus.deci_mode = DECI_AVG;
        bus.deci_clr  = 1'b0;
        @(negedge ad_clk);
        chk_en = 1'b1;
        @(negedge ad_clk);
        check("reset_data", bus.deci_data, 0);
        check("reset_valid", bus.deci_valid, 0);

        // Ramp, N=2, average
        clear_log();
        rst_n = 1'b1;
        drive(777);
        for (int i = 0; i < 12; i++) drive(i);
        check("ramp_count", log_data.size(), 3);
        check("ramp_avg0", log_data[0], 1);
        check("ramp_avg1", log_data[1], 5);
        check("ramp_avg2", log_data[2], 9);
        check("ramp_period", log_cyc[2] - log_cyc[1], 4);

        // N=3 max / min / point, with a mid-window mode change in the point window
        bus.deci_exp  = 4'd3;
        bus.deci_mode = DECI_MAX;
        pulse_clr(c);
        clear_log();
        foreach (win8[i]) drive(win8[i]);
        bus.deci_mode = DECI_MIN;
        foreach (win8[i]) drive(win8[i]);
        bus.deci_mode = DECI_POINT;
        for (int i = 0; i < 3; i++) drive(win8[i]);
        bus.deci_mode = DECI_MAX;
        for (int i = 3; i < 8; i++) drive(win8[i]);
        check("mmp_count", log_data.size(), 3);
        check("max_result", log_data[0], 4095);
        check("min_result", log_data[1], 0);
        check("point_result", log_data[2], 5);

        // N=0: every sample is its own window
        bus.deci_exp  = 4'd0;
        bus.deci_mode = DECI_MIN;
        pulse_clr(c);
        clear_log();
        foreach (vals[i]) drive(vals[i]);
        check("n0_count", log_data.size(), 6);
        foreach (vals[i]) check("n0_passthru", log_data[i], vals[i]);
        check("n0_period", log_cyc[5] - log_cyc[4], 1);

        // Exponent change 2 -> 4 mid-window
        bus.deci_exp  = 4'd2;
        bus.deci_mode = DECI_AVG;
        pulse_clr(c);
        clear_log();
        drive(10);
        drive(20);
        bus.deci_exp = 4'd4;
        drive(30);
        drive(40);
        for (int i = 0; i < 16; i++) drive(i * 3);
        check("cfg_count", log_data.size(), 2);
        check("cfg_avg_old", log_data[0], 25);
        check("cfg_avg_new", log_data[1], 22);
        check("cfg_period", log_cyc[1] - log_cyc[0], 16);

        // Exponent 15 clamps to 10
        bus.deci_exp  = 4'd15;
        bus.deci_mode = DECI_MAX;
        pulse_clr(c);
        clear_log();
        for (int i = 0; i < 2048; i++) drive(i);
        check("clamp_count", log_data.size(), 2);
        check("clamp_max0", log_data[0], 1023);
        check("clamp_max1", log_data[1], 2047);
        check("clamp_period", log_cyc[1] - log_cyc[0], 1024);

        // Clear exactly at window end
        bus.deci_exp  = 4'd2;
        bus.deci_mode = DECI_AVG;
        pulse_clr(c);
        clear_log();
        drive(4);
        drive(4);
        drive(4);
        pulse_clr(c);
        check("clr_no_strobe", bus.deci_valid, 0);
        check("clr_data_held", bus.deci_data, 2047);
        drive(8);
        drive(9);
        drive(10);
        drive(11);
        check("clr_count", log_data.size(), 1);
        check("clr_avg", log_data[0], 9);
        check("clr_latency", log_cyc[0] - c, 5);

        // Reset mid-window, N=4 average
        bus.deci_exp  = 4'd4;
        bus.deci_mode = DECI_AVG;
        pulse_clr(c);
        for (int i = 0; i < 5; i++) drive(4000);
        rst_n         = 1'b0;
        bus.deci_mode = DECI_MAX;
        for (int i = 0; i < 3; i++) drive(4000);
        check("midrst_data", bus.deci_data, 0);
        check("midrst_valid", bus.deci_valid, 0);
        clear_log();
        rst_n         = 1'b1;
        bus.deci_mode = DECI_AVG;
        rel = cyc + 1;
        drive(4000);
        for (int i = 0; i < 16; i++) drive(i * 2);
        check("post_rst_count", log_data.size(), 1);
        check("post_rst_avg", log_data[0], 15);
        check("post_rst_latency", log_cyc[0] - rel, 17);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
